// File: rtl/traffic_phase_sequencer_if.sv
// Control and status bundle between a supervisory block and the traffic phase sequencer.
interface traffic_phase_sequencer_if #(
  parameter int NUM_PHASES = 4
);
  logic                    GO;
  logic [NUM_PHASES-1:0]   DEMAND;
  logic                    FLASH;
  logic [2*NUM_PHASES-1:0] LIGHTS;
  logic [2:0]              ACTIVE_PHASE;
  logic [2:0]              STATE;
  logic                    PHASE_DONE;

  modport master (
    output GO, DEMAND, FLASH,
    input  LIGHTS, ACTIVE_PHASE, STATE, PHASE_DONE
  );

  modport slave (
    input  GO, DEMAND, FLASH,
    output LIGHTS, ACTIVE_PHASE, STATE, PHASE_DONE
  );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Demand-actuated junction controller: serves one signal group at a time, skips idle groups,
// extends green under demand, and supports a GO freeze plus a flashing maintenance mode.
module traffic_phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int CW         = 8,
  parameter int T_RY       = 2,
  parameter int T_GREEN    = 4,
  parameter int T_MAXGRN   = 8,
  parameter int T_YEL      = 2,
  parameter int T_ALLRED   = 1,
  parameter int T_FLASH    = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  traffic_phase_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_ALLRED   = 3'd0,
    ST_REDYEL   = 3'd1,
    ST_GREEN    = 3'd2,
    ST_YELLOW   = 3'd3,
    ST_FLASHING = 3'd4
  } state_e;

  localparam logic [1:0] LT_G  = 2'b00;
  localparam logic [1:0] LT_Y  = 2'b01;
  localparam logic [1:0] LT_R  = 2'b10;
  localparam logic [1:0] LT_RY = 2'b11;

  localparam int FW = (T_FLASH > 1) ? $clog2(T_FLASH) : 1;

  localparam logic [CW-1:0] RY_LAST      = CW'(T_RY - 1);
  localparam logic [CW-1:0] GRN_MIN_LAST = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] GRN_MAX_LAST = CW'(T_MAXGRN - 1);
  localparam logic [CW-1:0] YEL_LAST     = CW'(T_YEL - 1);
  localparam logic [CW-1:0] ALLRED_LAST  = CW'(T_ALLRED - 1);
  localparam logic [FW-1:0] FLASH_LAST   = FW'(T_FLASH - 1);
  localparam logic [2:0]    LAST_PHASE   = 3'(NUM_PHASES - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              phase_q, phase_d;
  logic                    flash_bit_q, flash_bit_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic                    done_q, done_d;
  logic [2*NUM_PHASES-1:0] lights_q, lights_d;
  logic [2:0]              rr_phase;
  logic                    cur_demand;

  assign cur_demand = |(bus.DEMAND & (NUM_PHASES'(1) << phase_q));

  // Round-robin pick: walk from farthest to nearest so the nearest requester after
  // the current group wins; the current group itself (k = NUM_PHASES) is the fallback.
  always_comb begin
    rr_phase = phase_q;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      if (|(bus.DEMAND & (NUM_PHASES'(1) << ((int'(phase_q) + k) % NUM_PHASES)))) begin
        rr_phase = 3'((int'(phase_q) + k) % NUM_PHASES);
      end
    end
  end

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    flash_bit_d = flash_bit_q;
    fcnt_d      = fcnt_q;
    done_d      = 1'b0;

    if (state_q == ST_FLASHING) begin
      if (!bus.FLASH) begin
        state_d     = ST_ALLRED;
        cnt_d       = '0;
        phase_d     = LAST_PHASE;
        flash_bit_d = 1'b0;
        fcnt_d      = '0;
      end else if (fcnt_q == FLASH_LAST) begin
        fcnt_d      = '0;
        flash_bit_d = ~flash_bit_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end else if (bus.GO) begin
      unique case (state_q)
        ST_ALLRED: begin
          if (cnt_q != ALLRED_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else if (bus.FLASH) begin
            state_d     = ST_FLASHING;
            cnt_d       = '0;
            fcnt_d      = '0;
            flash_bit_d = 1'b0;
          end else if (|bus.DEMAND) begin
            state_d = ST_REDYEL;
            cnt_d   = '0;
            phase_d = rr_phase;
          end
          // No demand: rest here with cnt parked on its last value.
        end
        ST_REDYEL: begin
          if (cnt_q == RY_LAST) begin
            state_d = ST_GREEN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GREEN: begin
          if (cnt_q >= GRN_MIN_LAST &&
              (!cur_demand || bus.FLASH || cnt_q == GRN_MAX_LAST)) begin
            state_d = ST_YELLOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_YELLOW: begin
          if (cnt_q == YEL_LAST) begin
            state_d = ST_ALLRED;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Lights are decoded from the next state so the registered copy moves with STATE.
  always_comb begin
    lights_d = {NUM_PHASES{LT_R}};
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (state_d == ST_FLASHING) begin
        lights_d[2*i +: 2] = flash_bit_d ? LT_Y : LT_R;
      end else if (3'(i) == phase_d) begin
        case (state_d)
          ST_REDYEL: lights_d[2*i +: 2] = LT_RY;
          ST_GREEN:  lights_d[2*i +: 2] = LT_G;
          ST_YELLOW: lights_d[2*i +: 2] = LT_Y;
          default:   lights_d[2*i +: 2] = LT_R;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset acts without waiting for CLK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_ALLRED;
      cnt_q       <= '0;
      phase_q     <= LAST_PHASE;
      flash_bit_q <= 1'b0;
      fcnt_q      <= '0;
      done_q      <= 1'b0;
      lights_q    <= {NUM_PHASES{LT_R}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      flash_bit_q <= flash_bit_d;
      fcnt_q      <= fcnt_d;
      done_q      <= done_d;
      lights_q    <= lights_d;
    end
  end

  assign bus.LIGHTS       = lights_q;
  assign bus.STATE        = state_q;
  assign bus.ACTIVE_PHASE = phase_q;
  assign bus.PHASE_DONE   = done_q;

endmodule
